// File: rtl/radix2_divider.sv
// Radix-2 restoring divider for the EX-stage div/divu/rem/remu ops.
// One quotient bit per cycle; divide-by-zero resolves in a single cycle.
module radix2_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remain,
  output logic             div_valid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remain_q;
  logic             valid_q;

  logic [WIDTH:0]   rsh_d;
  logic             ge_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;

  // Dividend register doubles as the quotient: MSB shifts out, new bit in.
  always_comb begin
    rsh_d = {rem_q, dvd_q[WIDTH-1]};
    ge_d  = rsh_d >= {1'b0, dvs_q};
    rem_d = ge_d ? WIDTH'(rsh_d - {1'b0, dvs_q})
                 : rsh_d[WIDTH-1:0];
    dvd_d = {dvd_q[WIDTH-2:0], ge_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quotient_q <= '0;
      remain_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q <= a;
            dvs_q <= b;
            rem_q <= '0;
            cnt_q <= '0;
            if (b == '0) begin
              quotient_q <= '1;
              remain_q   <= a;
              valid_q    <= 1'b1;
              state_q    <= DONE;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!start) begin
            state_q <= IDLE;
          end else begin
            dvd_q <= dvd_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              quotient_q <= dvd_d;
              remain_q   <= rem_d;
              valid_q    <= 1'b1;
              state_q    <= DONE;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign remain    = remain_q;
  assign div_valid = valid_q;

endmodule

// File: tb/tb_radix2_divider.sv
// Directed + random bench for radix2_divider.
// Expected results are queued at issue and popped on div_valid.
module tb_radix2_divider;

  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remain;
  logic         div_valid;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } res_t;

  res_t         sb[$];
  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  always #5 clk = ~clk;

  radix2_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .quotient (quotient),
    .remain   (remain),
    .div_valid(div_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] av,
                        input logic [W-1:0] bv,
                        input bit hold);
    res_t e;
    bit   early;
    bit   moved;
    e.q = (bv == '0) ? '1 : av / bv;
    e.r = (bv == '0) ? av : av % bv;
    sb.push_back(e);
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    early = 1'b0;
    moved = 1'b0;
    if (bv != '0) begin
      for (int i = 0; i < W; i++) begin
        if (div_valid !== 1'b0) early = 1'b1;
        if (quotient !== last_q || remain !== last_r) moved = 1'b1;
        a = $urandom;
        b = $urandom;
        tick();
      end
    end
    chk("early_valid", W'(early), '0);
    chk("busy_hold", W'(moved), '0);
    chk("valid", W'(div_valid), W'(1));
    e = sb.pop_front();
    chk("quotient", quotient, e.q);
    chk("remain", remain, e.r);
    last_q = e.q;
    last_r = e.r;
    if (!hold) start = 1'b0;
    tick();
    chk("valid_pulse", W'(div_valid), '0);
    chk("done_hold_q", quotient, last_q);
  endtask

  initial begin
    bit           stray;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_q", quotient, '0);
    chk("rst_r", remain, '0);
    chk("rst_v", W'(div_valid), '0);
    tick();
    tick();
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'h0000_1234, 32'd0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(32'd0, 32'd5, 1'b0);

    // abort mid-BUSY by dropping start
    a     = 32'd50;
    b     = 32'd6;
    start = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) tick();
    start = 1'b0;
    tick();
    stray = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (div_valid !== 1'b0) stray = 1'b1;
      if (quotient !== last_q || remain !== last_r) stray = 1'b1;
      tick();
    end
    chk("abort_quiet", W'(stray), '0);
    chk("abort_q", quotient, last_q);
    chk("abort_r", remain, last_r);
    run_op(32'd50, 32'd6, 1'b0);

    // asynchronous reset mid-operation
    a     = 32'd1000;
    b     = 32'd3;
    start = 1'b1;
    tick();
    for (int i = 0; i < 19; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_q", quotient, '0);
    chk("midrst_r", remain, '0);
    chk("midrst_v", W'(div_valid), '0);
    tick();
    tick();
    chk("midrst_hold_v", W'(div_valid), '0);
    start  = 1'b0;
    rst_n  = 1'b1;
    last_q = '0;
    last_r = '0;
    tick();
    chk("postrst_v", W'(div_valid), '0);
    run_op(32'd1000, 32'd3, 1'b0);

    for (int n = 0; n < 300; n++) begin
      ra = $urandom;
      case ($urandom_range(3))
        0: rb = W'($urandom_range(15) + 1);
        1: rb = ra >> $urandom_range(W - 1);
        default: rb = $urandom;
      endcase
      if ($urandom_range(99) < 5) rb = '0;
      run_op(ra, rb, n != 299 && $urandom_range(1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
